// File: rtl/mem_arbiter_if.sv
// Client request/return channels and memory strobes for the two-client memory arbiter.
// Purely structural: no logic and no latency of its own.
// Backpressure travels as per-client ready. The arbiter is the slave and the clients/memory side is the master.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req0_write;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  req0_rvalid;
    logic [DATA_WIDTH-1:0] req0_rdata;

    logic                  req1_valid;
    logic                  req1_write;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  req1_rvalid;
    logic [DATA_WIDTH-1:0] req1_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, req0_rvalid, req0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, req1_rvalid, req1_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    // Client / memory side
    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, req0_rvalid, req0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, req1_rvalid, req1_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for two clients sharing one single-port synchronous memory.
// Latency: a write commits 1 cycle after acceptance; read data returns 2 cycles after acceptance.
// Backpressure: ready is offered only in IDLE, so there is one transaction in flight at a time.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  ptr;       // client that wins when both are valid
    logic                  owner;     // client that owns the transaction in flight
    logic                  grant0;
    logic                  grant1;
    logic                  read_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic                  rvalid0_q;
    logic                  rvalid1_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: write = IDLE->ISSUE->IDLE, read = IDLE->ISSUE->RWAIT->IDLE
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = (grant0 || grant1) ? ISSUE : IDLE;
            ISSUE:   state_nxt = write_q ? IDLE : RWAIT;
            RWAIT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: combinational round-robin grant, offered only while IDLE
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || !ptr);
            grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr);
        end
    end

    // Request capture, strobe sequencing and pointer update. The address and
    // write data stay put after the strobes drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= 1'b0;
            owner   <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant0) begin
            ptr     <= 1'b1;
            owner   <= 1'b0;
            read_q  <= !bus.req0_write;
            write_q <= bus.req0_write;
            addr_q  <= bus.req0_addr;
            wdata_q <= bus.req0_wdata;
        end else if (grant1) begin
            ptr     <= 1'b0;
            owner   <= 1'b1;
            read_q  <= !bus.req1_write;
            write_q <= bus.req1_write;
            addr_q  <= bus.req1_addr;
            wdata_q <= bus.req1_wdata;
        end else if (state == ISSUE) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end
    end

    // Read return: memory data is valid during RWAIT and is steered only to the owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= (state == RWAIT) && !owner;
            rvalid1_q <= (state == RWAIT) &&  owner;
            if ((state == RWAIT) && !owner) begin
                rdata0_q <= bus.mem_rdata;
            end
            if ((state == RWAIT) && owner) begin
                rdata1_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.req0_rvalid = rvalid0_q;
    assign bus.req1_rvalid = rvalid1_q;
    assign bus.req0_rdata  = rdata0_q;
    assign bus.req1_rdata  = rdata1_q;
    assign bus.mem_read    = read_q;
    assign bus.mem_write   = write_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.busy        = (state != IDLE);
endmodule
